search_sched: RTL and testbench

SEARCH_SCHED -- requirements
Module: search_sched

---
 rtl/search_sched.sv | 126 ++++++++++++
 tb/tb_search_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/search_sched.sv
// Full-search motion-estimation scheduler: issues a raster scan of candidate offsets to an
// external pipelined tree adder and keeps the minimum-|sum| candidate. Option: SEARCH_EARLY_EXIT_EN.
module search_sched #(
    parameter int DATA_W    = 9,
    parameter int SUM_W     = 17,
    parameter int ADDER_LAT = 8,
    parameter int SEARCH_R  = 4,
    parameter int OFF_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    src_ready,
    input  logic signed [SUM_W-1:0] sum_in,
    output logic                    adder_en,
    output logic                    cand_valid,
    output logic signed [OFF_W-1:0] cand_dx,
    output logic signed [OFF_W-1:0] cand_dy,
    output logic                    busy,
    output logic                    done,
    output logic signed [OFF_W-1:0] best_dx,
    output logic signed [OFF_W-1:0] best_dy,
    output logic [SUM_W-1:0]        best_cost
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic signed [OFF_W-1:0] R_P = OFF_W'(SEARCH_R);
    localparam logic signed [OFF_W-1:0] R_N = OFF_W'(-SEARCH_R);
    localparam logic [ADDER_LAT-1:0] TOP = ADDER_LAT'(1) << (ADDER_LAT - 1);

    if (SUM_W <= DATA_W) begin : g_bad_width
        $error("search_sched: SUM_W must exceed DATA_W");
    end

    state_e                            state_q;
    logic signed [OFF_W-1:0]           ptr_dx_q, ptr_dy_q, ptr_dx_d, ptr_dy_d;
    logic signed [OFF_W-1:0]           best_dx_q, best_dy_q;
    logic [SUM_W-1:0]                  best_cost_q;
    logic [ADDER_LAT-1:0]              vld_q;
    logic [ADDER_LAT-1:0][OFF_W-1:0]   tdx_q, tdy_q;
    logic                              last_cand, eval, drained, early_exit;
    logic [SUM_W-1:0]                  cost;

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign adder_en   = (state_q == ISSUE) || (state_q == DRAIN);
    assign cand_valid = (state_q == ISSUE) && src_ready;
    assign cand_dx    = ptr_dx_q;
    assign cand_dy    = ptr_dy_q;
    assign best_dx    = best_dx_q;
    assign best_dy    = best_dy_q;
    assign best_cost  = best_cost_q;

    // Negation in SUM_W bits maps -2^(SUM_W-1) onto 2^(SUM_W-1) when read unsigned.
    assign cost    = sum_in[SUM_W-1] ? $unsigned(-sum_in) : $unsigned(sum_in);
    assign eval    = adder_en && vld_q[ADDER_LAT-1];
    assign drained = (vld_q & ~TOP) == '0;

`ifdef SEARCH_EARLY_EXIT_EN
    assign early_exit = eval && (cost == '0);
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        last_cand = (ptr_dx_q == R_P) && (ptr_dy_q == R_P);
        ptr_dx_d  = ptr_dx_q + OFF_W'(1);
        ptr_dy_d  = ptr_dy_q;
        if (ptr_dx_q == R_P) begin
            ptr_dx_d = R_N;
            ptr_dy_d = ptr_dy_q + OFF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_dx_q    <= '0;
            ptr_dy_q    <= '0;
            best_dx_q   <= '0;
            best_dy_q   <= '0;
            best_cost_q <= '1;
            vld_q       <= '0;
            tdx_q       <= '0;
            tdy_q       <= '0;
        end else begin
            if (adder_en) begin
                for (int i = ADDER_LAT - 1; i > 0; i--) begin
                    vld_q[i] <= vld_q[i-1];
                    tdx_q[i] <= tdx_q[i-1];
                    tdy_q[i] <= tdy_q[i-1];
                end
                vld_q[0] <= cand_valid;
                tdx_q[0] <= ptr_dx_q;
                tdy_q[0] <= ptr_dy_q;
            end
            if (eval && (cost < best_cost_q)) begin
                best_cost_q <= cost;
                best_dx_q   <= $signed(tdx_q[ADDER_LAT-1]);
                best_dy_q   <= $signed(tdy_q[ADDER_LAT-1]);
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q     <= ISSUE;
                    best_cost_q <= '1;
                    best_dx_q   <= '0;
                    best_dy_q   <= '0;
                    ptr_dx_q    <= R_N;
                    ptr_dy_q    <= R_N;
                end
                ISSUE: begin
                    if (cand_valid && !last_cand) begin
                        ptr_dx_q <= ptr_dx_d;
                        ptr_dy_q <= ptr_dy_d;
                    end
                    if (early_exit || (cand_valid && last_cand)) state_q <= DRAIN;
                end
                // The entry in the top stage, if any, is evaluated on this same edge.
                DRAIN: if (drained) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_search_sched.sv
// Scoreboard bench for search_sched: an 8-stage delay-line adder model feeds sum_in and a
// negedge monitor checks each done pulse against queued expectations.
module tb_search_sched;

    localparam int SUM_W = 17;
    localparam int OFF_W = 4;

    logic                    clk = 1'b0;
    logic                    rst_n, start, src_ready;
    logic signed [SUM_W-1:0] sum_in;
    logic                    adder_en, cand_valid, busy, done;
    logic signed [OFF_W-1:0] cand_dx, cand_dy, best_dx, best_dy;
    logic [SUM_W-1:0]        best_cost;

    search_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_ready(src_ready), .sum_in(sum_in),
        .adder_en(adder_en), .cand_valid(cand_valid), .cand_dx(cand_dx), .cand_dy(cand_dy),
        .busy(busy), .done(done), .best_dx(best_dx), .best_dy(best_dy), .best_cost(best_cost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dx;
        int dy;
        longint cost;
        int lat;
        int nval;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, kstart = 0, vbase = 0, vcount = 0, done_cnt = 0;
    int   mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder model: 0 => (dx-1)^2+(dy+2)^2+5, 1 => its negation, 2 => -65536, 3 => |dx|+|dy|
    function automatic int fsum(int dx, int dy);
        int b;
        b = (dx - 1) * (dx - 1) + (dy + 2) * (dy + 2) + 5;
        case (mode)
            0: return b;
            1: return -b;
            2: return -65536;
            default: return (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
        endcase
    endfunction

    logic signed [SUM_W-1:0] pipe [8];
    always @(posedge clk) begin
        if (adder_en) begin
            for (int i = 7; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= SUM_W'(fsum(int'(cand_dx), int'(cand_dy)));
        end
    end
    assign sum_in = pipe[7];

    task automatic chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cand_valid) vcount++;
        if (done) begin
            done_cnt++;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("best_dx", longint'(best_dx), e.dx);
                chk("best_dy", longint'(best_dy), e.dy);
                chk("best_cost", longint'(best_cost), e.cost);
                chk("done_latency", cyc + 1 - kstart, e.lat);
                chk("issue_count", vcount - vbase, e.nval);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one search; toggle makes src_ready alternate starting high in the first issue cycle.
    task automatic run(int m, bit toggle, int edx, int edy, longint ecost, int elat, int enval);
        exp_t e;
        int   n;
        mode = m;
        start = 1'b1;
        src_ready = 1'b1;
        tick();
        start = 1'b0;
        kstart = cyc;
        vbase = vcount;
        e.dx = edx; e.dy = edy; e.cost = ecost; e.lat = elat; e.nval = enval;
        q.push_back(e);
        n = 0;
        while (q.size() != 0 && n < 400) begin
            tick();
            n++;
            if (toggle) src_ready = ~src_ready;
            start = (!toggle && n == 10);
        end
        start = 1'b0;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
            void'(q.pop_front());
        end
        src_ready = 1'b1;
        tick();
        tick();
        chk("busy_after_done", longint'(busy), 0);
        chk("best_cost_hold", longint'(best_cost), ecost);
    endtask

    initial begin
        int k, d0;
        rst_n = 1'b0;
        start = 1'b0;
        src_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_adder_en", longint'(adder_en), 0);
        chk("rst_cand_valid", longint'(cand_valid), 0);
        chk("rst_cand_dx", longint'(cand_dx), 0);
        chk("rst_best_dy", longint'(best_dy), 0);
        chk("rst_best_cost", longint'(best_cost), 131071);
        rst_n = 1'b1;
        tick();

        run(0, 1'b0, 1, -2, 5, 90, 81);
        run(1, 1'b0, 1, -2, 5, 90, 81);
        run(2, 1'b0, -4, -4, 65536, 90, 81);
        run(0, 1'b1, 1, -2, 5, 170, 81);

        // Abort mid-search with reset sampled at edge k+40
        mode = 0;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc;
        chk("busy_in_search", longint'(busy), 1);
        while (cyc < k + 39) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", longint'(busy), 0);
        chk("abort_cand_valid", longint'(cand_valid), 0);
        chk("abort_best_cost", longint'(best_cost), 131071);
        tick();
        rst_n = 1'b1;
        repeat (60) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        run(0, 1'b0, 1, -2, 5, 90, 81);

`ifdef SEARCH_EARLY_EXIT_EN
        run(3, 1'b0, 0, 0, 0, 58, 49);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
